// File: rtl/pe_feeder_if.sv
// Bundle of job-command, source-stream and PE-facing signals for pe_feeder.
// master = the feeder itself, slave = whoever supplies commands/data and consumes PE pins.
interface pe_feeder_if #(
  parameter int WIDTH = 16,
  parameter int PW    = 3,
  parameter int LW    = 14,
  parameter int SW    = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [PW-1:0]    cmd_period;
  logic [LW-1:0]    cmd_lmac;
  logic [SW-1:0]    cmd_shft;
  logic             src_valid;
  logic             src_ready;
  logic [WIDTH-1:0] src_weight;
  logic [WIDTH-1:0] src_feature;
  logic             iconfig;
  logic             config_en;
  logic             start;
  logic             in_en;
  logic [WIDTH-1:0] weight;
  logic [WIDTH-1:0] feature;
  logic             busy;
  logic             done;

  modport master (
    input  cmd_valid, cmd_period, cmd_lmac, cmd_shft,
    input  src_valid, src_weight, src_feature,
    output cmd_ready, src_ready, iconfig, config_en, start,
    output in_en, weight, feature, busy, done
  );

  modport slave (
    output cmd_valid, cmd_period, cmd_lmac, cmd_shft,
    output src_valid, src_weight, src_feature,
    input  cmd_ready, src_ready, iconfig, config_en, start,
    input  in_en, weight, feature, busy, done
  );
endinterface

// File: rtl/pe_feeder.sv
// Single-PE feeder: shifts a job config into the PE serially, pulses start, then
// streams source pairs as nPeriod bursts of nLMAC beats separated by nSHFT idle cycles.
module pe_feeder #(
  parameter int WIDTH       = 16,
  parameter int MAX_nPERIOD = 8,
  parameter int MAX_nLMAC   = 12288,
  parameter int MAX_nSHFT   = 192,
  parameter int START_GAP   = 4
) (
  input  logic          clk,
  input  logic          rst,
  pe_feeder_if.master   bus
);
  localparam int PW  = $clog2(MAX_nPERIOD);
  localparam int LW  = $clog2(MAX_nLMAC);
  localparam int SW  = $clog2(MAX_nSHFT);
  localparam int CL  = PW + LW + SW;
  localparam int SQW = $clog2(CL + START_GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CONFIG, S_START, S_WAIT, S_BURST, S_GAP, S_DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CL-1:0]    r_cfg, w_cfg_nxt;
  logic [CL-1:0]    r_sh, w_sh_nxt;
  logic [SQW-1:0]   r_seq, w_seq_nxt;
  logic [PW-1:0]    r_per, w_per_nxt;
  logic [LW-1:0]    r_beat, w_beat_nxt;
  logic [SW-1:0]    r_gap, w_gap_nxt;
  logic             w_icfg_nxt;

  logic             r_cmd_ready, r_src_ready, r_iconfig, r_config_en;
  logic             r_start, r_in_en, r_busy, r_done;
  logic [WIDTH-1:0] r_weight, r_feature;

  logic [CL-1:0]    w_cmd_cfg;
  logic [PW-1:0]    w_period;
  logic [LW-1:0]    w_lmac;
  logic [SW-1:0]    w_shft;
  logic             w_cmd_acc, w_src_acc;
  logic             w_last_beat, w_last_per, w_last_gap;

  assign w_cmd_cfg = {bus.cmd_period, bus.cmd_lmac, bus.cmd_shft};
  assign w_period  = r_cfg[CL-1 -: PW];
  assign w_lmac    = r_cfg[SW +: LW];
  assign w_shft    = r_cfg[SW-1:0];

  // ready flops mirror the current state, so they double as state decodes
  assign w_cmd_acc = bus.cmd_valid && r_cmd_ready;
  assign w_src_acc = bus.src_valid && r_src_ready;

  // one extra bit so the +1 never wraps before the compare
  assign w_last_beat = ({1'b0, r_beat} + 1'b1) == {1'b0, w_lmac};
  assign w_last_per  = ({1'b0, r_per}  + 1'b1) == {1'b0, w_period};
  assign w_last_gap  = ({1'b0, r_gap}  + 1'b1) == {1'b0, w_shft};

  always_comb begin
    w_state_nxt = r_state;
    w_cfg_nxt   = r_cfg;
    w_sh_nxt    = r_sh;
    w_seq_nxt   = r_seq;
    w_per_nxt   = r_per;
    w_beat_nxt  = r_beat;
    w_gap_nxt   = r_gap;
    w_icfg_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_acc) begin
          w_cfg_nxt   = w_cmd_cfg;
          w_icfg_nxt  = w_cmd_cfg[0];
          w_sh_nxt    = w_cmd_cfg >> 1;
          w_seq_nxt   = '0;
          w_per_nxt   = '0;
          w_beat_nxt  = '0;
          w_gap_nxt   = '0;
          w_state_nxt = S_CONFIG;
        end
      end
      S_CONFIG: begin
        if (r_seq == SQW'(CL - 1)) begin
          w_state_nxt = S_START;
        end else begin
          w_seq_nxt  = r_seq + 1'b1;
          w_icfg_nxt = r_sh[0];
          w_sh_nxt   = r_sh >> 1;
        end
      end
      S_START: begin
        w_seq_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_seq == SQW'(START_GAP - 1)) begin
          w_state_nxt = (w_period != '0 && w_lmac != '0) ? S_BURST : S_DONE;
        end else begin
          w_seq_nxt = r_seq + 1'b1;
        end
      end
      S_BURST: begin
        if (w_src_acc) begin
          if (w_last_beat) begin
            w_beat_nxt = '0;
            if (w_last_per) begin
              w_state_nxt = S_DONE;
            end else begin
              w_per_nxt = r_per + 1'b1;
              if (w_shft != '0) begin
                w_gap_nxt   = '0;
                w_state_nxt = S_GAP;
              end
            end
          end else begin
            w_beat_nxt = r_beat + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (w_last_gap) begin
          w_gap_nxt   = '0;
          w_state_nxt = S_BURST;
        end else begin
          w_gap_nxt = r_gap + 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cfg       <= '0;
      r_sh        <= '0;
      r_seq       <= '0;
      r_per       <= '0;
      r_beat      <= '0;
      r_gap       <= '0;
      r_cmd_ready <= 1'b1;
      r_src_ready <= 1'b0;
      r_iconfig   <= 1'b0;
      r_config_en <= 1'b0;
      r_start     <= 1'b0;
      r_in_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_weight    <= '0;
      r_feature   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cfg       <= w_cfg_nxt;
      r_sh        <= w_sh_nxt;
      r_seq       <= w_seq_nxt;
      r_per       <= w_per_nxt;
      r_beat      <= w_beat_nxt;
      r_gap       <= w_gap_nxt;
      // all pins are registered decodes of the state being entered
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      r_src_ready <= (w_state_nxt == S_BURST);
      r_config_en <= (w_state_nxt == S_CONFIG);
      r_start     <= (w_state_nxt == S_START);
      r_done      <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_iconfig   <= w_icfg_nxt;
      r_in_en     <= w_src_acc;
      if (w_src_acc) begin
        r_weight  <= bus.src_weight;
        r_feature <= bus.src_feature;
      end
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.src_ready = r_src_ready;
  assign bus.iconfig   = r_iconfig;
  assign bus.config_en = r_config_en;
  assign bus.start     = r_start;
  assign bus.in_en     = r_in_en;
  assign bus.weight    = r_weight;
  assign bus.feature   = r_feature;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder: table of jobs with hand-computed timing, plus
// hand-written stall, window and mid-job reset sequences.
module tb_pe_feeder;
  localparam int WIDTH = 16, PW = 3, LW = 14, SW = 8, L = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pe_feeder_if #(.WIDTH(WIDTH), .PW(PW), .LW(LW), .SW(SW)) bus();
  pe_feeder #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errs = 0;
  int checks = 0;

  logic t_cfgen[L], t_icfg[L], t_start[L], t_in_en[L], t_done[L];
  logic t_busy[L], t_cmdr[L], t_srcr[L];
  logic [WIDTH-1:0] t_w[L], t_f[L];

  typedef struct {
    int p, l, s, slo, shi;
    logic [24:0] icfg;
    int done_c, n_in, first_in, last_in, n_srcr, rdy_back;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycle 0 is the command-accept cycle; outputs are sampled at each negedge.
  task automatic run_job(input int p, input int l, input int s,
                         input int slo, input int shi, input int rst_cyc);
    int idx = 0;
    @(posedge clk);
    for (int k = 0; k < L; k++) begin
      #1;
      rst             = (k == rst_cyc) ? 1'b0 : 1'b1;
      bus.cmd_valid   = (k == 0 || k == 5);
      bus.cmd_period  = PW'(p);
      bus.cmd_lmac    = LW'(l);
      bus.cmd_shft    = SW'(s);
      bus.src_valid   = !(k >= slo && k <= shi);
      bus.src_weight  = idx[WIDTH-1:0];
      bus.src_feature = 16'h8000 | idx[WIDTH-1:0];
      @(negedge clk);
      t_cfgen[k] = bus.config_en; t_icfg[k] = bus.iconfig; t_start[k] = bus.start;
      t_in_en[k] = bus.in_en;     t_done[k] = bus.done;    t_busy[k]  = bus.busy;
      t_cmdr[k]  = bus.cmd_ready; t_srcr[k] = bus.src_ready;
      t_w[k]     = bus.weight;    t_f[k]    = bus.feature;
      if (bus.src_valid && bus.src_ready) idx++;
      @(posedge clk);
    end
    #1;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.src_valid = 1'b0;
  endtask

  task automatic check_entry(input vec_t v, input string tag);
    logic [24:0] icv;
    int n_cfg, n_st, st_c, n_dn, dn_c, n_in, f_in, l_in, n_sr, rb, bad, b;
    icv = '0; n_cfg = 0; n_st = 0; st_c = -1; n_dn = 0; dn_c = -1;
    n_in = 0; f_in = -1; l_in = -1; n_sr = 0; rb = -1; bad = 0; b = 0;
    for (int k = 1; k <= 25; k++) icv[k-1] = t_icfg[k];
    for (int k = 0; k < L; k++) begin
      if (t_cfgen[k]) n_cfg++;
      if (t_start[k]) begin n_st++; if (st_c < 0) st_c = k; end
      if (t_done[k])  begin n_dn++; if (dn_c < 0) dn_c = k; end
      if (t_srcr[k])  n_sr++;
      if (t_in_en[k]) begin
        n_in++; if (f_in < 0) f_in = k; l_in = k;
        if (t_w[k] !== WIDTH'(b) || t_f[k] !== (16'h8000 | WIDTH'(b))) bad++;
        b++;
      end
      if (rb < 0 && k > v.done_c && t_cmdr[k]) rb = k;
    end
    chk({tag, " config_en cycles"}, n_cfg, 25);
    chk({tag, " config_en window"}, {t_cfgen[1], t_cfgen[25], t_cfgen[26]}, 3'b110);
    chk({tag, " iconfig bits"}, icv, v.icfg);
    chk({tag, " start count"}, n_st, 1);
    chk({tag, " start cycle"}, st_c, 26);
    chk({tag, " done count"}, n_dn, 1);
    chk({tag, " done cycle"}, dn_c, v.done_c);
    chk({tag, " in_en count"}, n_in, v.n_in);
    chk({tag, " first in_en"}, f_in, v.first_in);
    chk({tag, " last in_en"}, l_in, v.last_in);
    chk({tag, " src_ready count"}, n_sr, v.n_srcr);
    chk({tag, " cmd_ready back"}, rb, v.rdy_back);
    chk({tag, " busy edges"}, {t_busy[1], t_busy[v.done_c], t_busy[v.done_c+1]}, 3'b110);
    chk({tag, " data beats bad"}, bad, 0);
  endtask

  initial begin
    int bad;
    tbl[0] = '{2, 8,  3, -1, -2, 25'h0800803, 50, 16, 32, 50, 16, 51};
    tbl[1] = '{2, 8,  3, 33, 34, 25'h0800803, 52, 16, 32, 52, 18, 53};
    tbl[2] = '{3, 4,  0, -1, -2, 25'h0C00400, 43, 12, 32, 43, 12, 44};
    tbl[3] = '{0, 5,  3, -1, -2, 25'h0000503, 31,  0, -1, -1,  0, 32};
    tbl[4] = '{2, 0,  1, -1, -2, 25'h0800001, 31,  0, -1, -1,  0, 32};
    tbl[5] = '{1, 1,  5, -1, -2, 25'h0400105, 32,  1, 32, 32,  1, 33};

    bus.cmd_valid = 1'b0; bus.cmd_period = '0; bus.cmd_lmac = '0; bus.cmd_shft = '0;
    bus.src_valid = 1'b0; bus.src_weight = '0; bus.src_feature = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ctrl {cfgen,icfg,start,in_en,done,busy,srcr,cmdr}",
        {bus.config_en, bus.iconfig, bus.start, bus.in_en, bus.done,
         bus.busy, bus.src_ready, bus.cmd_ready}, 8'b00000001);
    chk("reset data", {bus.weight, bus.feature}, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_job(tbl[i].p, tbl[i].l, tbl[i].s, tbl[i].slo, tbl[i].shi, -1);
      check_entry(tbl[i], $sformatf("job%0d", i));
      if (i == 0) begin
        bad = 0;
        for (int k = 0; k < L; k++) begin
          if (t_srcr[k]  !== ((k >= 31 && k <= 38) || (k >= 42 && k <= 49))) bad++;
          if (t_in_en[k] !== ((k >= 32 && k <= 39) || (k >= 43 && k <= 50))) bad++;
        end
        chk("nominal ready/in_en windows bad", bad, 0);
      end
      if (i == 1) begin
        chk("stall in_en 33..35", {t_in_en[33], t_in_en[34], t_in_en[35]}, 3'b100);
        chk("stall first burst end", {t_in_en[41], t_in_en[42]}, 2'b10);
        chk("stall gap src_ready 40..44",
            {t_srcr[40], t_srcr[41], t_srcr[42], t_srcr[43], t_srcr[44]}, 5'b10001);
      end
      if (i == 2) begin
        bad = 0;
        for (int k = 32; k <= 43; k++) if (t_in_en[k] !== 1'b1) bad++;
        chk("shft0 continuous in_en gaps", bad, 0);
      end
    end

    run_job(2, 8, 3, -1, -2, 35);
    chk("rst busy before abort", t_busy[35], 1'b1);
    chk("rst ctrl after abort",
        {t_cfgen[36], t_icfg[36], t_start[36], t_in_en[36], t_done[36],
         t_busy[36], t_srcr[36], t_cmdr[36]}, 8'b00000001);
    chk("rst data after abort", {t_w[36], t_f[36]}, 32'h0);
    bad = 0;
    for (int k = 0; k < L; k++) if (t_done[k]) bad++;
    chk("rst no done pulse", bad, 0);

    run_job(tbl[0].p, tbl[0].l, tbl[0].s, tbl[0].slo, tbl[0].shi, -1);
    check_entry(tbl[0], "post-reset job");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
